// File: rtl/reg_file_param.sv
// Parametrised architectural register file: three registered read ports, PC port,
// two write ports with write-first bypass, NZCV flags, and post-reset clear sequencer.
module reg_file_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_IDX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] rd_addr3,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  output logic [DATA_W-1:0] pc_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              wr2_en,
  input  logic [ADDR_W-1:0] wr2_addr,
  input  logic [DATA_W-1:0] wr2_data,
  input  logic [3:0]        flag_en,
  input  logic [3:0]        flag_in,
  output logic              N,
  output logic              Z,
  output logic              C,
  output logic              V,
  output logic              busy
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_IDX);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd2_q, rd3_q, pc_q;
  logic [DATA_W-1:0] rd1_d, rd2_d, rd3_d, pc_d;
  logic [3:0]        flag_q, flag_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == CLR_LAST) state_d = RUN;
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q == CLEAR);
  end

  // Port 1 is assigned last so it wins a same-address double write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[clr_idx_q[ADDR_W-1:0]] <= '0;
      end else begin
        if (wr2_en) mem_q[wr2_addr] <= wr2_data;
        if (wr1_en) mem_q[wr1_addr] <= wr1_data;
      end
    end
  end

  function automatic logic [DATA_W-1:0] bypass_rd(input logic [ADDR_W-1:0] a);
    if (wr1_en && (wr1_addr == a))      return wr1_data;
    else if (wr2_en && (wr2_addr == a)) return wr2_data;
    else                                return mem_q[a];
  endfunction

  always_comb begin
    rd1_d  = '0;
    rd2_d  = '0;
    rd3_d  = '0;
    pc_d   = '0;
    flag_d = flag_q;
    if (state_q == RUN) begin
      rd1_d  = bypass_rd(rd_addr1);
      rd2_d  = bypass_rd(rd_addr2);
      rd3_d  = bypass_rd(rd_addr3);
      pc_d   = bypass_rd(PC_ADDR);
      flag_d = (flag_en & flag_in) | (~flag_en & flag_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q  <= '0;
      rd2_q  <= '0;
      rd3_q  <= '0;
      pc_q   <= '0;
      flag_q <= '0;
    end else begin
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      rd3_q  <= rd3_d;
      pc_q   <= pc_d;
      flag_q <= flag_d;
    end
  end

  assign rd_data1 = rd1_q;
  assign rd_data2 = rd2_q;
  assign rd_data3 = rd3_q;
  assign pc_data  = pc_q;
  assign N        = flag_q[3];
  assign Z        = flag_q[2];
  assign C        = flag_q[1];
  assign V        = flag_q[0];

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: clear sequence, bypass, write priority, PC port, flags, mid-run reset.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr1, rd_addr2, rd_addr3;
  logic [31:0] rd_data1, rd_data2, rd_data3, pc_data;
  logic        wr1_en, wr2_en;
  logic [3:0]  wr1_addr, wr2_addr;
  logic [31:0] wr1_data, wr2_data;
  logic [3:0]  flag_en, flag_in;
  logic        N, Z, C, V, busy;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_param #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
    .pc_data(pc_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
    .flag_en(flag_en), .flag_in(flag_in),
    .N(N), .Z(Z), .C(C), .V(V), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    wr2_en = 1'b0; wr2_addr = '0; wr2_data = '0;
    flag_en = '0; flag_in = '0;
  endtask

  // Drives wr1/flag writes throughout clear; they must be ignored.
  task automatic run_clear(input string tag);
    wr1_en = 1'b1; wr1_addr = 4'd2; wr1_data = 32'hCAFEF00D;
    flag_en = 4'hF; flag_in = 4'hF;
    for (int i = 1; i <= 16; i++) begin
      step();
      n_cmp++;
      if (busy !== (i < 16)) begin
        n_err++;
        $display("FAIL %s_busy edge %0d: got %b want %b", tag, i, busy, (i < 16));
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_addr1 = '0; rd_addr2 = '0; rd_addr3 = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (busy !== 1'b1 || {N, Z, C, V} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_state: busy=%b nzcv=%b want busy=1 nzcv=0000", busy, {N, Z, C, V});
    end
    n_cmp++;
    if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || rd_data3 !== 32'h0 || pc_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_reads: %h %h %h pc=%h want all 0", rd_data1, rd_data2, rd_data3, pc_data);
    end
    rst = 1'b0;
    run_clear("reset");
    n_cmp++;
    if ({N, Z, C, V} !== 4'b0000) begin
      n_err++;
      $display("FAIL clear_flags_ignored: got %b want 0000", {N, Z, C, V});
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr1 = 4'(a);
      step();
      n_cmp++;
      if (rd_data1 !== 32'h0) begin
        n_err++;
        $display("FAIL clear_read addr %0d: got %h want 00000000", a, rd_data1);
      end
    end
  endtask

  task automatic test_bypass();
    wr1_en = 1'b1; wr1_addr = 4'd3; wr1_data = 32'hDEADBEEF; rd_addr1 = 4'd3;
    step();
    n_cmp++;
    if (rd_data1 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL bypass_wr1: got %h want deadbeef", rd_data1);
    end
    idle_inputs();
    step();
    n_cmp++;
    if (rd_data1 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL array_read3: got %h want deadbeef", rd_data1);
    end
  endtask

  task automatic test_double_write();
    wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 32'h11111111;
    wr2_en = 1'b1; wr2_addr = 4'd5; wr2_data = 32'h22222222;
    rd_addr2 = 4'd5;
    step();
    n_cmp++;
    if (rd_data2 !== 32'h11111111) begin
      n_err++;
      $display("FAIL dual_bypass: got %h want 11111111", rd_data2);
    end
    idle_inputs();
    rd_addr3 = 4'd5;
    step();
    n_cmp++;
    if (rd_data2 !== 32'h11111111 || rd_data3 !== 32'h11111111) begin
      n_err++;
      $display("FAIL dual_array: got %h/%h want 11111111", rd_data2, rd_data3);
    end
  endtask

  task automatic test_pc();
    n_cmp++;
    if (pc_data !== 32'h0) begin
      n_err++;
      $display("FAIL pc_before: got %h want 00000000", pc_data);
    end
    wr2_en = 1'b1; wr2_addr = 4'd15; wr2_data = 32'h00000100;
    rd_addr1 = 4'd0;
    step();
    n_cmp++;
    if (pc_data !== 32'h00000100) begin
      n_err++;
      $display("FAIL pc_bypass: got %h want 00000100", pc_data);
    end
    n_cmp++;
    if (rd_data1 !== 32'h0) begin
      n_err++;
      $display("FAIL entry0_untouched: got %h want 00000000", rd_data1);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    wr2_en = 1'b1; wr2_addr = 4'd9; wr2_data = 32'h0BADF00D; rd_addr3 = 4'd9;
    step();
    n_cmp++;
    if (rd_data3 !== 32'h0BADF00D) begin
      n_err++;
      $display("FAIL bypass_wr2: got %h want 0badf00d", rd_data3);
    end
    wr2_en = 1'b0;
    wr1_en = 1'b1; wr1_addr = 4'd10; wr1_data = 32'h80000001; rd_addr3 = 4'd10; rd_addr2 = 4'd9;
    step();
    n_cmp++;
    if (rd_data3 !== 32'h80000001 || rd_data2 !== 32'h0BADF00D) begin
      n_err++;
      $display("FAIL b2b: got %h/%h want 80000001/0badf00d", rd_data3, rd_data2);
    end
    idle_inputs();
  endtask

  task automatic test_flags();
    flag_en = 4'b1010; flag_in = 4'b1111;
    step();
    n_cmp++;
    if ({N, Z, C, V} !== 4'b1010) begin
      n_err++;
      $display("FAIL flags_1: got %b want 1010", {N, Z, C, V});
    end
    flag_en = 4'b0001; flag_in = 4'b0000;
    step();
    n_cmp++;
    if ({N, Z, C, V} !== 4'b1010) begin
      n_err++;
      $display("FAIL flags_2: got %b want 1010", {N, Z, C, V});
    end
    flag_en = 4'b0101; flag_in = 4'b0101;
    step();
    n_cmp++;
    if ({N, Z, C, V} !== 4'b1111) begin
      n_err++;
      $display("FAIL flags_3: got %b want 1111", {N, Z, C, V});
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 32'hA5A5A5A5;
    step();
    idle_inputs();
    rd_addr1 = 4'd7;
    step();
    n_cmp++;
    if (rd_data1 !== 32'hA5A5A5A5 || {N, Z, C, V} !== 4'b1111) begin
      n_err++;
      $display("FAIL pre_reset: got %h nzcv=%b want a5a5a5a5 1111", rd_data1, {N, Z, C, V});
    end
    rst = 1'b1;
    wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 32'h12345678;
    step();
    idle_inputs();
    n_cmp++;
    if ({N, Z, C, V} !== 4'b0000 || busy !== 1'b1 || rd_data1 !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset: nzcv=%b busy=%b rd1=%h want 0000 1 0", {N, Z, C, V}, busy, rd_data1);
    end
    rst = 1'b0;
    run_clear("mid_reset");
    rd_addr1 = 4'd7; rd_addr2 = 4'd2;
    step();
    n_cmp++;
    if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
      n_err++;
      $display("FAIL post_reset_read: got %h/%h want 0/0", rd_data1, rd_data2);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_double_write();
    test_pc();
    test_back_to_back();
    test_flags();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the core register file: a DEPTH x DATA_W architectural register array with three registered read ports, a dedicated PC read port, two write ports with write-first bypass, and a separate NZCV flag register with per-flag update mask. After reset, a hardware clear sequencer zeroes the array one entry per cycle and reports busy. It sits between decode (read addresses) and writeback (result/base writeback, flag update) in the ARM datapath.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
- PC_IDX, 15, index driven on pc_data
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- rd_addr1, rd_addr2, rd_addr3  in  ADDR_W  read addresses
- rd_data1, rd_data2, rd_data3  out  DATA_W  registered read data
- pc_data  out  DATA_W  registered contents of entry PC_IDX
- wr1_en  in  1  write port 1 enable (ALU result)
- wr1_addr  in  ADDR_W; wr1_data  in  DATA_W
- wr2_en  in  1  write port 2 enable (base/link writeback)
- wr2_addr  in  ADDR_W; wr2_data  in  DATA_W
- flag_en  in  4  per-flag update mask, bit3..0 = N,Z,C,V
- flag_in  in  4  new flag values, bit3..0 = N,Z,C,V
- N, Z, C, V  out  1 each  current flag register bits
- busy  out  1  high while reset or clear sequence in progress

## Operation
- States: CLEAR, RUN. Clear index clr_idx, ADDR_W+1 bits.
- rst=1 at an edge: state<=CLEAR, clr_idx<=0, rd_data1..3<=0, pc_data<=0, flags<=0. Array not written while rst=1.
- CLEAR, rst=0: entry[clr_idx]<=0, clr_idx<=clr_idx+1; on the edge writing clr_idx=DEPTH-1, state<=RUN.
- CLEAR: wr1/wr2/flag_en ignored; all read outputs register 0; busy=1 (combinational from state).
- RUN: busy=0; writes: wr1_en -> entry[wr1_addr]<=wr1_data; wr2_en -> entry[wr2_addr]<=wr2_data.
- Same-address double write: port 1 wins; port 2 data discarded.
- Reads (RUN): each rd_dataN / pc_data registers, in priority order: wr1_data if wr1_en and address match; else wr2_data if wr2_en and match; else entry[addr]. Write-first bypass.
- Flags (RUN): for each bit i, flag_en[i]=1 -> flag[i]<=flag_in[i]; else hold. Flags are independent of array entries; no entry aliases the CPSR.
- All widths exact; no sign or zero extension anywhere.

## Timing
- Read latency 1 cycle: address at edge k, data valid after edge k, held until next edge.
- Write-to-read: same-cycle bypass, so read at edge k of address written at edge k returns new data.
- Flag update visible on N/Z/C/V after the updating edge; no bypass onto flag outputs.
- busy: high from first edge with rst=1 through exactly DEPTH edges after rst deasserts; low after the edge clearing entry DEPTH-1.
- First usable write: edge with busy=0 sampled low.
- rst during CLEAR or RUN: sequence restarts at clr_idx=0; in-flight writes on that edge dropped.
- rst held several cycles: clear sequence does not advance until rst=0.

## Test plan
- Reset then idle, ADDR_W=4: rst=1 one cycle -> busy=1 for 16 edges after deassert, then 0; reads of every address return 0; N,Z,C,V=0.
- RUN, wr1 entry 3 <= 0xDEADBEEF, rd_addr1=3 same edge -> rd_data1=0xDEADBEEF after that edge (bypass); next cycle still 0xDEADBEEF from array.
- Same edge wr1 and wr2 to entry 5 (0x11111111 vs 0x22222222), rd_addr2=5 -> rd_data2=0x11111111; later read of 5 = 0x11111111.
- wr2 entry 15 <= 0x00000100 -> pc_data=0x00000100 after that edge; wr1 entry 0 unaffected.
- Flags 0000, flag_en=1010, flag_in=1111 -> NZCV=1010; then flag_en=0001, flag_in=0000 -> NZCV=1010 unchanged; flag_en=0101, flag_in=0101 -> NZCV=1111.
- Reset mid-RUN after writing entry 7=0xA5A5A5A5 and NZCV=1111, assert wr1_en on reset edge -> flags 0, busy=1 for 16 edges, write ignored, entry 7 reads 0 afterward.
